md_seq: RTL



---
 rtl/md_seq_pkg.sv | 37 +++
 rtl/md_step.sv | 39 +++
 rtl/md_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/md_seq_pkg.sv
// -----------------------------------------------------------------------------
// md_seq_pkg
// Shared definitions for the multiply/divide unit: the MD-class ALU opcodes,
// the sequencer state encoding, the iteration count and small helpers.
// -----------------------------------------------------------------------------
package md_seq_pkg;

    localparam logic [3:0] ALU_MULT  = 4'd8;
    localparam logic [3:0] ALU_MULTU = 4'd9;
    localparam logic [3:0] ALU_DIV   = 4'd10;
    localparam logic [3:0] ALU_DIVU  = 4'd11;

    localparam int unsigned MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_FIX
    } md_state_t;

    typedef enum logic {
        MD_OP_MUL,
        MD_OP_DIV
    } md_op_t;

    function automatic logic is_md_op(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) ||
               (op == ALU_DIV)  || (op == ALU_DIVU);
    endfunction

    // Magnitude of a 32-bit value; 0x8000_0000 stays 0x8000_0000, which is
    // the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/md_step.sv
// -----------------------------------------------------------------------------
// md_step
// Combinational single iteration of the shift-add multiplier / restoring
// divider.
//   i_acc     : 64-bit accumulator ({hi_part, multiplier} or {rem, quot})
//   i_operand : multiplicand (multiply) or divisor (divide) magnitude
//   i_op      : MD_OP_MUL or MD_OP_DIV
//   o_acc     : accumulator after one iteration
// -----------------------------------------------------------------------------
module md_step
    import md_seq_pkg::*;
(
    input  logic [63:0] i_acc,
    input  logic [31:0] i_operand,
    input  md_op_t      i_op,
    output logic [63:0] o_acc
);

    logic [32:0] w_sum;
    logic [32:0] w_diff;
    logic        w_ge;

    always_comb begin
        w_sum  = {1'b0, i_acc[63:32]} + (i_acc[0] ? {1'b0, i_operand} : 33'd0);
        // Shifted remainder is 33 bits; it is always below 2*divisor, so a set
        // top bit means the subtraction succeeds and the difference fits 32 bits.
        w_diff = i_acc[63:31] - {1'b0, i_operand};
        w_ge   = i_acc[63] | ~w_diff[32];

        if (i_op == MD_OP_MUL) begin
            o_acc = {w_sum, i_acc[31:1]};
        end else if (w_ge) begin
            o_acc = {w_diff[31:0], i_acc[30:0], 1'b1};
        end else begin
            o_acc = {i_acc[62:0], 1'b0};
        end
    end

endmodule

// File: rtl/md_seq.sv
// -----------------------------------------------------------------------------
// md_seq
// Iterative 32-cycle multiply/divide unit owning the architectural HI/LO.
//   clk, rst        : clock, synchronous active-high reset
//   start, ALUOp    : launch request from EX (MULT/MULTU/DIV/DIVU only)
//   data_in1/2      : rs (multiplicand/dividend), rt (multiplier/divisor)
//   hi_we, lo_we    : MTHI/MTLO strobes with data on wdata (IDLE only)
//   busy            : operation in flight
//   done            : one-cycle pulse when HI/LO take a result
//   hi, lo          : HI/LO registers
// -----------------------------------------------------------------------------
module md_seq
    import md_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  ALUOp,
    input  logic [31:0] data_in1,
    input  logic [31:0] data_in2,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   r_state, w_state_nxt;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_opnd;
    logic [31:0] r_dividend;
    md_op_t      r_op;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic        r_dz;
    logic [31:0] r_hi, r_lo;
    logic        r_done;

    logic        w_launch;
    logic        w_signed;
    logic        w_is_div;
    logic [31:0] w_mag1, w_mag2;
    logic [63:0] w_acc_nxt;
    logic [63:0] w_prod;
    logic [31:0] w_quot, w_rem;

    assign w_launch = start && is_md_op(ALUOp);
    assign w_signed = (ALUOp == ALU_MULT) || (ALUOp == ALU_DIV);
    assign w_is_div = (ALUOp == ALU_DIV)  || (ALUOp == ALU_DIVU);
    assign w_mag1   = mag32(data_in1, w_signed);
    assign w_mag2   = mag32(data_in2, w_signed);

    md_step u_step (
        .i_acc     (r_acc),
        .i_operand (r_opnd),
        .i_op      (r_op),
        .o_acc     (w_acc_nxt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= MD_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (w_launch) w_state_nxt = MD_RUN;
            MD_RUN:  if (r_cnt == 5'(MD_ITER - 1)) w_state_nxt = MD_FIX;
            MD_FIX:  w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (r_state != MD_IDLE);
        done = r_done;
        hi   = r_hi;
        lo   = r_lo;
    end

    // Sign fix-up of the magnitude result
    always_comb begin
        w_prod = r_neg_res ? (64'd0 - r_acc) : r_acc;
        w_quot = r_neg_res ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
        w_rem  = r_neg_rem ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    end

    // Datapath, counter and HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_dividend <= '0;
            r_op       <= MD_OP_MUL;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dz       <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (w_launch) begin
                        // Upper half cleared; the low half carries the multiplier
                        // (shifted out LSB-first) or the dividend (shifted out MSB-first).
                        r_op       <= w_is_div ? MD_OP_DIV : MD_OP_MUL;
                        r_opnd     <= w_is_div ? w_mag2 : w_mag1;
                        r_acc      <= {32'd0, (w_is_div ? w_mag1 : w_mag2)};
                        r_cnt      <= '0;
                        r_dividend <= data_in1;
                        r_neg_res  <= w_signed && (data_in1[31] ^ data_in2[31]);
                        r_neg_rem  <= w_signed && data_in1[31];
                        r_dz       <= w_is_div && (data_in2 == 32'd0);
                    end else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                MD_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 5'd1;
                end
                MD_FIX: begin
                    r_done <= 1'b1;
                    if (r_op == MD_OP_MUL) begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end else if (r_dz) begin
                        r_hi <= r_dividend;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
